// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: 3-stage pipelined floating-point multiplier.
// Subnormal inputs are read as zero and tiny results are flushed to zero.
// Rounding is to nearest, ties to even. Tags ride along in order.
// A single global stall freezes every stage while the output is held.
module fp_mul_pipe #(
  parameter int unsigned EXP_W = 5,
  parameter int unsigned MAN_W = 10,
  parameter int unsigned TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out,
  output logic [TAG_W-1:0]     out_tag,
  output logic [3:0]           out_flags
);

  localparam int unsigned W    = 1 + EXP_W + MAN_W;
  localparam int unsigned MW   = MAN_W + 1;             // mantissa with hidden bit
  localparam int unsigned PW   = 2 * MW;                // full product width
  localparam int unsigned EW   = EXP_W + 2;             // signed working exponent
  localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int unsigned EMAX = (1 << EXP_W) - 1;

  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // Operand class after decode; K_NUM means both operands are finite non-zero
  typedef enum logic [1:0] {
    K_NUM  = 2'd0,
    K_ZERO = 2'd1,
    K_INF  = 2'd2,
    K_NAN  = 2'd3
  } kind_e;

  logic stall;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // ---------------------------------------------------------------- S1 decode
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;

  assign {sa, ea, ma} = a;
  assign {sb, eb, mb} = b;

  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
  kind_e            d_kind;
  logic             d_inv;
  logic [PW-1:0]    d_prod;
  logic [EW-1:0]    d_esum;

  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (&ea) & (ma == '0);
  assign b_inf  = (&eb) & (mb == '0);
  assign a_nan  = (&ea) & (ma != '0);
  assign b_nan  = (&eb) & (mb != '0);
  assign a_snan = a_nan & ~ma[MAN_W-1];
  assign b_snan = b_nan & ~mb[MAN_W-1];

  // Classify the operand pair; NaN wins, then inf x zero, then inf, then zero
  always_comb begin
    d_kind = K_NUM;
    d_inv  = 1'b0;
    if (a_nan | b_nan) begin
      d_kind = K_NAN;
      d_inv  = a_snan | b_snan;
    end else if ((a_inf & b_zero) | (b_inf & a_zero)) begin
      d_kind = K_NAN;
      d_inv  = 1'b1;
    end else if (a_inf | b_inf) begin
      d_kind = K_INF;
    end else if (a_zero | b_zero) begin
      d_kind = K_ZERO;
    end
    d_prod = PW'({1'b1, ma}) * PW'({1'b1, mb});
    d_esum = EW'(ea) + EW'(eb) - EW'(BIAS);
  end

  logic             s1_v, s1_sign, s1_inv;
  kind_e            s1_kind;
  logic [PW-1:0]    s1_prod;
  logic [EW-1:0]    s1_esum;
  logic [TAG_W-1:0] s1_tag;

  // Stage 1 register: decoded class, raw product and biased exponent sum
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_sign <= 1'b0;
      s1_inv  <= 1'b0;
      s1_kind <= K_NUM;
      s1_prod <= '0;
      s1_esum <= '0;
      s1_tag  <= '0;
    end else if (!stall) begin
      s1_v    <= in_valid;
      s1_sign <= sa ^ sb;
      s1_inv  <= d_inv;
      s1_kind <= d_kind;
      s1_prod <= d_prod;
      s1_esum <= d_esum;
      s1_tag  <= in_tag;
    end
  end

  // ------------------------------------------------------- S2 normalise/round
  logic             n_msb, n_g, n_r, n_st, n_up, n_carry, n_inx;
  logic [PW-1:0]    n_norm;
  logic [MW-1:0]    n_mant;
  logic [MW:0]      n_rnd;
  logic [MAN_W-1:0] n_frac;
  logic [EW-1:0]    n_exp;

  // Align the product so its leading one sits at the top, then round RNE
  always_comb begin
    n_msb   = s1_prod[PW-1];
    n_norm  = n_msb ? s1_prod : (s1_prod << 1);
    n_mant  = n_norm[PW-1 -: MW];
    n_g     = n_norm[MAN_W];
    n_r     = n_norm[MAN_W-1];
    n_st    = |n_norm[MAN_W-2:0];
    n_up    = n_g & (n_r | n_st | n_mant[0]);
    n_rnd   = (MW+1)'(n_mant) + (MW+1)'(n_up);
    n_carry = n_rnd[MW];
    n_frac  = n_carry ? n_rnd[MW-1:1] : n_rnd[MW-2:0];
    n_exp   = s1_esum + EW'(n_msb) + EW'(n_carry);
    n_inx   = n_g | n_r | n_st;
  end

  logic             s2_v, s2_sign, s2_inv, s2_inx;
  kind_e            s2_kind;
  logic [EW-1:0]    s2_exp;
  logic [MAN_W-1:0] s2_frac;
  logic [TAG_W-1:0] s2_tag;

  // Stage 2 register: rounded fraction, post-round exponent, inexact
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v    <= 1'b0;
      s2_sign <= 1'b0;
      s2_inv  <= 1'b0;
      s2_inx  <= 1'b0;
      s2_kind <= K_NUM;
      s2_exp  <= '0;
      s2_frac <= '0;
      s2_tag  <= '0;
    end else if (!stall) begin
      s2_v    <= s1_v;
      s2_sign <= s1_sign;
      s2_inv  <= s1_inv;
      s2_inx  <= n_inx;
      s2_kind <= s1_kind;
      s2_exp  <= n_exp;
      s2_frac <= n_frac;
      s2_tag  <= s1_tag;
    end
  end

  // ------------------------------------------------------------- S3 pack
  logic         p_ovf, p_unf;
  logic [W-1:0] p_res;
  logic [3:0]   p_flags;

  // Resolve specials and exponent range into the final word and flags
  always_comb begin
    p_ovf   = ~s2_exp[EW-1] & (s2_exp >= EW'(EMAX));
    p_unf   = s2_exp[EW-1] | (s2_exp == '0);
    p_res   = {s2_sign, s2_exp[EXP_W-1:0], s2_frac};
    p_flags = {3'b000, s2_inx};
    case (s2_kind)
      K_NAN: begin
        p_res   = QNAN;
        p_flags = {s2_inv, 3'b000};
      end
      K_INF: begin
        p_res   = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        p_flags = 4'b0000;
      end
      K_ZERO: begin
        p_res   = {s2_sign, {(W-1){1'b0}}};
        p_flags = 4'b0000;
      end
      default: begin
        if (p_ovf) begin
          p_res   = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          p_flags = 4'b0101;
        end else if (p_unf) begin
          p_res   = {s2_sign, {(W-1){1'b0}}};
          p_flags = 4'b0011;
        end
      end
    endcase
  end

  // Output register; held unchanged whenever the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= '0;
      out_tag   <= '0;
      out_flags <= '0;
    end else if (!stall) begin
      out_valid <= s2_v;
      out       <= p_res;
      out_tag   <= s2_tag;
      out_flags <= p_flags;
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe: vector table plus stall/reset sequences, queue scoreboard.
module tb_fp_mul_pipe;

  localparam int unsigned EXP_W = 5;
  localparam int unsigned MAN_W = 10;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned W     = 1 + EXP_W + MAN_W;
  localparam int unsigned NVEC  = 23;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [3:0]   flg;
  } vec_t;

  typedef struct {
    logic [W-1:0]     res;
    logic [3:0]       flg;
    logic [TAG_W-1:0] tag;
  } sb_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]     a, b, out;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic [3:0]       out_flags;

  fp_mul_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_tag   (out_tag),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;

  int               n_tests = 0;
  int               n_fail  = 0;
  int               n_in    = 0;
  int               n_out   = 0;
  int               last_wait;
  logic [TAG_W-1:0] tag_ctr = '0;
  sb_t              exp_cur;
  sb_t              sb_q[$];
  vec_t             vt[NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard and hold monitor, sampled on the falling edge
  logic             held_v = 1'b0;
  logic [W-1:0]     held_out;
  logic [TAG_W-1:0] held_tag;
  logic [3:0]       held_flg;

  always @(negedge clk) begin
    if (rst) begin
      held_v <= 1'b0;
    end else begin
      if (held_v)
        check("stall_hold", {7'd0, out_valid, out, out_tag, out_flags},
              {7'd0, 1'b1, held_out, held_tag, held_flg});
      held_v   <= out_valid && !out_ready;
      held_out <= out;
      held_tag <= out_tag;
      held_flg <= out_flags;
      if (in_valid && in_ready) begin
        sb_q.push_back(exp_cur);
        n_in++;
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_output", 32'(sb_q.size()), 32'd1);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          check($sformatf("out[%0d]", n_out), 32'(out), 32'(e.res));
          check($sformatf("flags[%0d]", n_out), 32'(out_flags), 32'(e.flg));
          check($sformatf("tag[%0d]", n_out), 32'(out_tag), 32'(e.tag));
        end
        n_out++;
      end
    end
  end

  // Offer one operation and hold it until accepted; returns after the accept edge
  task automatic drive_op(input vec_t v);
    logic ok;
    ok        = 1'b0;
    last_wait = 0;
    a         = v.a;
    b         = v.b;
    in_tag    = tag_ctr;
    exp_cur   = '{v.res, v.flg, tag_ctr};
    in_valid  = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      last_wait++;
    end
    if (!ok) check("accept_timeout", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    tag_ctr  = tag_ctr + 1'b1;
  endtask

  // Issue one operation on an idle pipe and measure cycles to out_valid
  task automatic timed_op(input vec_t v, input string name);
    int lat;
    lat = 0;
    drive_op(v);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    check(name, 32'(lat), 32'd3);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

  initial begin
    vt[0]  = '{16'h3E00, 16'h4000, 16'h4200, 4'b0000};
    vt[1]  = '{16'h3C01, 16'h3C01, 16'h3C02, 4'b0001};
    vt[2]  = '{16'h7BFF, 16'h7BFF, 16'h7C00, 4'b0101};
    vt[3]  = '{16'h0400, 16'hB800, 16'h8000, 4'b0011};
    vt[4]  = '{16'h7C00, 16'h0000, 16'h7E00, 4'b1000};
    vt[5]  = '{16'h7C01, 16'h3C00, 16'h7E00, 4'b1000};
    vt[6]  = '{16'h3C00, 16'h3C00, 16'h3C00, 4'b0000};
    vt[7]  = '{16'hC000, 16'h3C00, 16'hC000, 4'b0000};
    vt[8]  = '{16'hFC00, 16'h4000, 16'hFC00, 4'b0000};
    vt[9]  = '{16'h0000, 16'hC200, 16'h8000, 4'b0000};
    vt[10] = '{16'h0001, 16'h3C00, 16'h0000, 4'b0000};
    vt[11] = '{16'h0001, 16'h7C00, 16'h7E00, 4'b1000};
    vt[12] = '{16'h7E00, 16'h3C00, 16'h7E00, 4'b0000};
    vt[13] = '{16'h3C00, 16'hFC01, 16'h7E00, 4'b1000};
    vt[14] = '{16'h7E00, 16'h0000, 16'h7E00, 4'b0000};
    vt[15] = '{16'h3E00, 16'h3C01, 16'h3E02, 4'b0001};
    vt[16] = '{16'h3E00, 16'h3C03, 16'h3E04, 4'b0001};
    vt[17] = '{16'h3DA8, 16'h3DA8, 16'h4000, 4'b0001};
    vt[18] = '{16'h7800, 16'h3C00, 16'h7800, 4'b0000};
    vt[19] = '{16'h7800, 16'h4000, 16'h7C00, 4'b0101};
    vt[20] = '{16'h0400, 16'h3C00, 16'h0400, 4'b0000};
    vt[21] = '{16'h0400, 16'h3BFF, 16'h0000, 4'b0011};
    vt[22] = '{16'hBE00, 16'hBE00, 16'h4080, 4'b0000};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    in_tag    = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out", 32'(out), 32'd0);
    check("rst_out_tag", 32'(out_tag), 32'd0);
    check("rst_out_flags", 32'(out_flags), 32'd0);
    rst = 1'b0;

    // Basic op with latency measurement, tag 3
    tag_ctr = 4'd3;
    timed_op(vt[0], "latency_basic");
    repeat (3) @(posedge clk);
    #1;

    // Whole table back to back
    for (int i = 0; i < NVEC; i++) drive_op(vt[i]);
    repeat (6) @(posedge clk);
    #1;

    // Eight back-to-back ops with the consumer stalled in cycles 4..7
    begin
      int base;
      base = n_out;
      fork
        begin
          for (int i = 0; i < 8; i++) drive_op(vt[i]);
        end
        begin
          for (int c = 0; c < 16; c++) begin
            out_ready = !(c >= 4 && c <= 7);
            @(negedge clk);
            if (c >= 4 && c <= 7) begin
              check($sformatf("stall_in_ready[c%0d]", c), 32'(in_ready), 32'd0);
              check($sformatf("stall_out_valid[c%0d]", c), 32'(out_valid), 32'd1);
            end
            @(posedge clk);
            #1;
          end
          out_ready = 1'b1;
        end
      join
      repeat (6) @(posedge clk);
      #1;
      check("stall_result_count", 32'(n_out - base), 32'd8);
    end

    // Reset with two ops in flight: nothing may emerge afterwards
    drive_op(vt[6]);
    drive_op(vt[7]);
    rst = 1'b1;
    sb_q.delete();
    n_out = n_in;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("midrst_idle[%0d]", k), 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    timed_op(vt[15], "latency_after_rst");
    repeat (3) @(posedge clk);
    #1;

    // Acceptance on the very first edge after reset release
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    timed_op(vt[22], "latency_first_edge");
    check("first_edge_accept_wait", 32'(last_wait), 32'd0);

    repeat (8) @(posedge clk);
    #1;
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    check("in_out_balance", 32'(n_out), 32'(n_in));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
